pipe_front_regs: RTL and testbench
==================================

# pipe_front_regs

Front-end pipeline state for the 5-stage RV32I core: the PC register, the IF/ID register and the control half of the ID/EX register. It carries out the stall, bubble and flush requests that the hazard-detection logic raises, so that one decision made during a cycle takes effect at the next clock edge. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- NOP_INSTR, 32'h0000_0013, canonical bubble instruction (addi x0,x0,0)
- CNT_W, 16, event counter width

Ports (single clock domain; reset is synchronous and active-low):
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- PCWriteEN  in  1  1 = PC may update
- IF_ID_WriteEN  in  1  1 = IF/ID may update
- NOP  in  1  1 = insert bubble into ID/EX
- Flush  in  1  1 = kill the instruction currently being fetched
- pc_next  in  XLEN  next PC (sequential or redirect target), chosen upstream
- if_instr  in  32  instruction fetched at pc
- id_rd  in  5  destination register decoded in ID
- id_mem_read  in  1  ID control field
- id_mem_write  in  1  ID control field
- id_reg_write  in  1  ID control field
- pc  out  XLEN  current fetch PC
- if_id_pc  out  XLEN  PC of the instruction held in IF/ID
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- id_ex_rd  out  5  registered rd
- id_ex_mem_read  out  1  registered control field
- id_ex_mem_write  out  1  registered control field
- id_ex_reg_write  out  1  registered control field
- id_ex_valid  out  1  ID/EX holds a real instruction
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

## Operation
Reset values (rst_n=0 at an edge):
- pc = RESET_PC
- if_id_pc = 0, if_id_instr = NOP_INSTR, if_id_valid = 0
- all id_ex_* = 0, id_ex_valid = 0
- both counters = 0

Reset overrides every other input.

Per-edge update, in priority order:
1. **Stall** (PCWriteEN=0 or IF_ID_WriteEN=0):
   - pc holds when PCWriteEN=0; IF/ID holds when IF_ID_WriteEN=0. The two enables act independently.
   - Flush is ignored in a stall cycle, even if it is asserted.
2. **Flush** (Flush=1 and no stall):
   - pc <= pc_next.
   - IF/ID loads if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=pc.
3. **Normal**:
   - pc <= pc_next.
   - IF/ID loads pc and if_instr, with if_id_valid=1.

ID/EX control:
- NOP=1: id_ex_mem_read, id_ex_mem_write, id_ex_reg_write and id_ex_valid all become 0. id_ex_rd becomes 0, so no downstream forwarding match is possible.
- NOP=0: registers the id_* fields, with id_ex_valid <= if_id_valid.
- ID/EX is never held. The branch or jump instruction in ID itself still advances during a Flush.

Counters:
- stall_cnt increments in every cycle where PCWriteEN=0.
- flush_cnt increments in every cycle where Flush=1 and no stall is in effect.
- Both saturate at all-ones and do not wrap.

## Timing
- All outputs are registered, with zero combinational paths from inputs to outputs.
- Request to effect: one cycle. A control value sampled at edge N is visible after edge N.
- A stall lasting K cycles holds pc and IF/ID for K edges and inserts K bubbles into ID/EX.
- Stall and Flush asserted in the same cycle: the stall wins, and the flush is counted only once it is presented without a stall.
- If rst_n drops in the middle of a stall, the next edge still applies full reset values.
- Counter at 2^CNT_W-1: it stays there while further events occur.

## Structure
- Shared package `core_pkg` holds NOP_INSTR, XLEN and the RESET_PC default.
- Sub-module `sat_counter` (parameter W; ports clk, rst_n, inc, count) is instantiated twice.
- The PC, IF/ID and ID/EX registers are written as one always block per register group.

## Test plan
- **Reset:** rst_n=0 for 2 cycles, then 1 with pc_next=pc+4. Expect pc=0x0 and if_id_instr=0x00000013 right after reset, then pc=0x4 and if_id_valid=1 one edge later.
- **Load-use stall:** PCWriteEN=0, IF_ID_WriteEN=0, NOP=1 for 1 cycle with pc=0x10. Expect pc still 0x10, IF/ID unchanged, id_ex_valid=0, id_ex_reg_write=0, stall_cnt=1.
- **Flush:** Flush=1 with pc_next=0x80 and if_instr=0xDEADBEEF. Expect pc=0x80, if_id_instr=0x00000013, if_id_valid=0, ID/EX loaded from id_* fields, flush_cnt=1.
- **Simultaneous:** Flush=1 together with PCWriteEN=0 and IF_ID_WriteEN=0. Expect the hold takes effect, flush_cnt unchanged, stall_cnt+1.
- **Saturation:** CNT_W=4 with 20 consecutive stall cycles. Expect stall_cnt=15.
- **Mid-stall reset:** rst_n=0 while PCWriteEN=0. Expect all reset values after the edge.

Source files
------------

// File: rtl/pipe_front_regs_pkg.sv
// Shared core definitions for the front-end pipeline registers: default
// widths and reset constants, the IF/ID update modes and the ID/EX control
// bundle.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam int          CNT_W     = 16;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // What the IF/ID register does at the next edge.
    typedef enum logic [1:0] {
        IFID_HOLD  = 2'd0,
        IFID_FLUSH = 2'd1,
        IFID_LOAD  = 2'd2
    } ifIdMode_e;

    // Control half of the ID/EX register.
    typedef struct packed {
        logic [4:0] rd;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       valid;
    } idExCtrl_t;

    // IF/ID update decision. A hold on IF/ID wins outright; a flush only
    // takes effect when neither enable is stalling, so a PC-only stall still
    // lets IF/ID load normally and the flush request is dropped.
    function automatic ifIdMode_e ifIdModeSel(input logic pcWriteEn,
                                              input logic ifIdWriteEn,
                                              input logic flush);
        ifIdMode_e mode;
        mode = IFID_LOAD;
        if (!ifIdWriteEn) begin
            mode = IFID_HOLD;
        end else if (flush && pcWriteEn) begin
            mode = IFID_FLUSH;
        end else begin
            mode = IFID_LOAD;
        end
        return mode;
    endfunction

endpackage

// File: rtl/pipe_front_regs_if.sv
// Bundle of hazard-control requests, fetch/decode inputs and the registered
// front-end pipeline state. The hazard/fetch side is the master; the
// register block is the slave.
interface pipe_front_regs_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);

    logic             PCWriteEN;
    logic             IF_ID_WriteEN;
    logic             NOP;
    logic             Flush;
    logic [XLEN-1:0]  pc_next;
    logic [31:0]      if_instr;
    logic [4:0]       id_rd;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_reg_write;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  if_id_pc;
    logic [31:0]      if_id_instr;
    logic             if_id_valid;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             id_ex_mem_write;
    logic             id_ex_reg_write;
    logic             id_ex_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output PCWriteEN, IF_ID_WriteEN, NOP, Flush, pc_next, if_instr,
               id_rd, id_mem_read, id_mem_write, id_reg_write,
        input  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_rd,
               id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
               id_ex_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  PCWriteEN, IF_ID_WriteEN, NOP, Flush, pc_next, if_instr,
               id_rd, id_mem_read, id_mem_write, id_reg_write,
        output pc, if_id_pc, if_id_instr, if_id_valid, id_ex_rd,
               id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
               id_ex_valid, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_front_regs_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic [W-1:0] countNext_s;
    logic         atMax_s;

    // Next count: step on an event unless already saturated.
    always_comb begin
        atMax_s     = &count_r;
        countNext_s = count_r;
        if (inc && !atMax_s) begin
            countNext_s = count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            countNext_s = count_r;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= countNext_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state of the RV32I core: PC, IF/ID and the control half
// of ID/EX. Stall, flush and bubble requests raised during a cycle take effect
// at the next rising edge; stall and flush events are counted for debug.
module pipe_front_regs #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_front_regs_if.slave  bus
);

    import core_pkg::*;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] ifIdPc_r;
    logic [31:0]     ifIdInstr_r;
    logic            ifIdValid_r;
    idExCtrl_t       idEx_r;

    idExCtrl_t       idExNext_s;
    ifIdMode_e       ifIdMode_s;
    logic            stallAny_s;
    logic            flushTake_s;
    logic            stallEvt_s;
    logic [CNT_W-1:0] stallCnt_s;
    logic [CNT_W-1:0] flushCnt_s;

    // Decode the hazard requests into register-group actions.
    always_comb begin
        stallAny_s  = ~bus.PCWriteEN | ~bus.IF_ID_WriteEN;
        flushTake_s = bus.Flush & ~stallAny_s;
        stallEvt_s  = ~bus.PCWriteEN;
        ifIdMode_s  = ifIdModeSel(bus.PCWriteEN, bus.IF_ID_WriteEN, bus.Flush);
        idExNext_s  = '{rd: 5'd0, memRead: 1'b0, memWrite: 1'b0,
                        regWrite: 1'b0, valid: 1'b0};
        if (bus.NOP) begin
            // Bubble: rd cleared too so nothing downstream can forward from it.
            idExNext_s = '{rd: 5'd0, memRead: 1'b0, memWrite: 1'b0,
                           regWrite: 1'b0, valid: 1'b0};
        end else begin
            idExNext_s = '{rd: bus.id_rd, memRead: bus.id_mem_read,
                           memWrite: bus.id_mem_write,
                           regWrite: bus.id_reg_write, valid: ifIdValid_r};
        end
    end

    // PC register: advances whenever PC writes are enabled (normal or flush).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (bus.PCWriteEN) begin
            pc_r <= bus.pc_next;
        end else begin
            pc_r <= pc_r;
        end
    end

    // IF/ID register: hold, kill the fetched instruction, or load it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifIdPc_r    <= {XLEN{1'b0}};
            ifIdInstr_r <= NOP_INSTR;
            ifIdValid_r <= 1'b0;
        end else begin
            case (ifIdMode_s)
                IFID_HOLD: begin
                    ifIdPc_r    <= ifIdPc_r;
                    ifIdInstr_r <= ifIdInstr_r;
                    ifIdValid_r <= ifIdValid_r;
                end
                IFID_FLUSH: begin
                    ifIdPc_r    <= pc_r;
                    ifIdInstr_r <= NOP_INSTR;
                    ifIdValid_r <= 1'b0;
                end
                IFID_LOAD: begin
                    ifIdPc_r    <= pc_r;
                    ifIdInstr_r <= bus.if_instr;
                    ifIdValid_r <= 1'b1;
                end
                default: begin
                    ifIdPc_r    <= ifIdPc_r;
                    ifIdInstr_r <= ifIdInstr_r;
                    ifIdValid_r <= ifIdValid_r;
                end
            endcase
        end
    end

    // ID/EX control register: never held, loads a bubble or the decoded fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idEx_r <= '{rd: 5'd0, memRead: 1'b0, memWrite: 1'b0,
                        regWrite: 1'b0, valid: 1'b0};
        end else begin
            idEx_r <= idExNext_s;
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallEvt_s),
        .count (stallCnt_s)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flushTake_s),
        .count (flushCnt_s)
    );

    assign bus.pc              = pc_r;
    assign bus.if_id_pc        = ifIdPc_r;
    assign bus.if_id_instr     = ifIdInstr_r;
    assign bus.if_id_valid     = ifIdValid_r;
    assign bus.id_ex_rd        = idEx_r.rd;
    assign bus.id_ex_mem_read  = idEx_r.memRead;
    assign bus.id_ex_mem_write = idEx_r.memWrite;
    assign bus.id_ex_reg_write = idEx_r.regWrite;
    assign bus.id_ex_valid     = idEx_r.valid;
    assign bus.stall_cnt       = stallCnt_s;
    assign bus.flush_cnt       = flushCnt_s;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs with a 4-bit counter width so that
// saturation is reachable quickly.
module tb_pipe_front_regs;

    localparam int TB_XLEN  = 32;
    localparam int TB_CNT_W = 4;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    pipe_front_regs_if #(.XLEN(TB_XLEN), .CNT_W(TB_CNT_W)) bus ();

    pipe_front_regs #(
        .XLEN      (TB_XLEN),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setCtl(input logic pcw, input logic ifw, input logic nop, input logic fl);
        bus.PCWriteEN     = pcw;
        bus.IF_ID_WriteEN = ifw;
        bus.NOP           = nop;
        bus.Flush         = fl;
    endtask

    task automatic setId(input logic [4:0] rd, input logic mr, input logic mw, input logic rw);
        bus.id_rd        = rd;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.id_reg_write = rw;
    endtask

    task automatic chkReset(input string pfx);
        chk({pfx, "_pc"},        bus.pc,                   32'h0000_0000);
        chk({pfx, "_ifid_pc"},   bus.if_id_pc,             32'h0000_0000);
        chk({pfx, "_ifid_ins"},  bus.if_id_instr,          32'h0000_0013);
        chk({pfx, "_ifid_v"},    {31'd0, bus.if_id_valid}, 32'd0);
        chk({pfx, "_idex_rd"},   {27'd0, bus.id_ex_rd},    32'd0);
        chk({pfx, "_idex_ctl"},  {29'd0, bus.id_ex_mem_read, bus.id_ex_mem_write,
                                  bus.id_ex_reg_write},     32'd0);
        chk({pfx, "_idex_v"},    {31'd0, bus.id_ex_valid}, 32'd0);
        chk({pfx, "_stall_cnt"}, {28'd0, bus.stall_cnt},   32'd0);
        chk({pfx, "_flush_cnt"}, {28'd0, bus.flush_cnt},   32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;

        // Reset for two edges.
        rst_n = 1'b0;
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        setId(5'd0, 1'b0, 1'b0, 1'b0);
        bus.pc_next  = 32'h0000_0000;
        bus.if_instr = 32'h0000_0000;
        step();
        step();
        chkReset("rst");

        // First fetch out of reset.
        rst_n        = 1'b1;
        bus.pc_next  = 32'h0000_0004;
        bus.if_instr = 32'h0010_0093;
        setId(5'd3, 1'b0, 1'b0, 1'b1);
        step();
        chk("f1_pc",       bus.pc,                   32'h0000_0004);
        chk("f1_ifid_pc",  bus.if_id_pc,             32'h0000_0000);
        chk("f1_ifid_ins", bus.if_id_instr,          32'h0010_0093);
        chk("f1_ifid_v",   {31'd0, bus.if_id_valid}, 32'd1);
        chk("f1_idex_rd",  {27'd0, bus.id_ex_rd},    32'd3);
        chk("f1_idex_v",   {31'd0, bus.id_ex_valid}, 32'd0);

        // Second fetch: ID/EX now inherits a valid IF/ID.
        bus.pc_next  = 32'h0000_0008;
        bus.if_instr = 32'h0020_0113;
        setId(5'd1, 1'b1, 1'b0, 1'b1);
        step();
        chk("f2_pc",       bus.pc,                       32'h0000_0008);
        chk("f2_ifid_pc",  bus.if_id_pc,                 32'h0000_0004);
        chk("f2_idex_v",   {31'd0, bus.id_ex_valid},     32'd1);
        chk("f2_idex_mr",  {31'd0, bus.id_ex_mem_read},  32'd1);
        chk("f2_idex_rd",  {27'd0, bus.id_ex_rd},        32'd1);

        bus.pc_next  = 32'h0000_0010;
        bus.if_instr = 32'h0030_2183;
        step();
        chk("f3_pc",       bus.pc,          32'h0000_0010);
        chk("f3_ifid_ins", bus.if_id_instr, 32'h0030_2183);

        // Load-use stall with bubble.
        setCtl(1'b0, 1'b0, 1'b1, 1'b0);
        bus.pc_next  = 32'h0000_0014;
        bus.if_instr = 32'h1111_1111;
        step();
        chk("lu_pc",       bus.pc,                       32'h0000_0010);
        chk("lu_ifid_pc",  bus.if_id_pc,                 32'h0000_0008);
        chk("lu_ifid_ins", bus.if_id_instr,              32'h0030_2183);
        chk("lu_idex_v",   {31'd0, bus.id_ex_valid},     32'd0);
        chk("lu_idex_rw",  {31'd0, bus.id_ex_reg_write}, 32'd0);
        chk("lu_idex_rd",  {27'd0, bus.id_ex_rd},        32'd0);
        chk("lu_stall",    {28'd0, bus.stall_cnt},       32'd1);

        // Only IF/ID held: PC moves, stall counter does not.
        setCtl(1'b1, 1'b0, 1'b0, 1'b0);
        bus.pc_next  = 32'h0000_0014;
        bus.if_instr = 32'h2222_2222;
        setId(5'd5, 1'b0, 1'b0, 1'b1);
        step();
        chk("ih_pc",       bus.pc,                   32'h0000_0014);
        chk("ih_ifid_ins", bus.if_id_instr,          32'h0030_2183);
        chk("ih_stall",    {28'd0, bus.stall_cnt},   32'd1);
        chk("ih_idex_rd",  {27'd0, bus.id_ex_rd},    32'd5);
        chk("ih_idex_v",   {31'd0, bus.id_ex_valid}, 32'd1);

        // Only PC held: IF/ID loads normally.
        setCtl(1'b0, 1'b1, 1'b0, 1'b0);
        bus.pc_next  = 32'h0000_0018;
        bus.if_instr = 32'h3333_3333;
        step();
        chk("ph_pc",       bus.pc,                 32'h0000_0014);
        chk("ph_ifid_pc",  bus.if_id_pc,           32'h0000_0014);
        chk("ph_ifid_ins", bus.if_id_instr,        32'h3333_3333);
        chk("ph_stall",    {28'd0, bus.stall_cnt}, 32'd2);

        // Flush to a redirect target.
        setCtl(1'b1, 1'b1, 1'b0, 1'b1);
        bus.pc_next  = 32'h0000_0080;
        bus.if_instr = 32'hDEAD_BEEF;
        setId(5'd7, 1'b0, 1'b1, 1'b0);
        step();
        chk("fl_pc",       bus.pc,                       32'h0000_0080);
        chk("fl_ifid_ins", bus.if_id_instr,              32'h0000_0013);
        chk("fl_ifid_v",   {31'd0, bus.if_id_valid},     32'd0);
        chk("fl_ifid_pc",  bus.if_id_pc,                 32'h0000_0014);
        chk("fl_idex_rd",  {27'd0, bus.id_ex_rd},        32'd7);
        chk("fl_idex_mw",  {31'd0, bus.id_ex_mem_write}, 32'd1);
        chk("fl_idex_v",   {31'd0, bus.id_ex_valid},     32'd1);
        chk("fl_flush",    {28'd0, bus.flush_cnt},       32'd1);

        // Flush together with a full stall: the stall wins.
        setCtl(1'b0, 1'b0, 1'b1, 1'b1);
        bus.pc_next  = 32'h0000_0100;
        bus.if_instr = 32'h4444_4444;
        step();
        chk("sim_pc",      bus.pc,                 32'h0000_0080);
        chk("sim_ifid_pc", bus.if_id_pc,           32'h0000_0014);
        chk("sim_flush",   {28'd0, bus.flush_cnt}, 32'd1);
        chk("sim_stall",   {28'd0, bus.stall_cnt}, 32'd3);

        // Same flush presented without a stall is now counted.
        setCtl(1'b1, 1'b1, 1'b0, 1'b1);
        bus.pc_next  = 32'h0000_0084;
        bus.if_instr = 32'h5555_5555;
        step();
        chk("fl2_pc",      bus.pc,                   32'h0000_0084);
        chk("fl2_ifid_pc", bus.if_id_pc,             32'h0000_0080);
        chk("fl2_idex_v",  {31'd0, bus.id_ex_valid}, 32'd0);
        chk("fl2_flush",   {28'd0, bus.flush_cnt},   32'd2);

        // Back to normal flow.
        setCtl(1'b1, 1'b1, 1'b0, 1'b0);
        bus.pc_next  = 32'h0000_0088;
        bus.if_instr = 32'h6666_6666;
        step();
        chk("n_pc",        bus.pc,                   32'h0000_0088);
        chk("n_ifid_ins",  bus.if_id_instr,          32'h6666_6666);
        chk("n_ifid_v",    {31'd0, bus.if_id_valid}, 32'd1);

        // Long stall: counter climbs from 3 and saturates at 15.
        setCtl(1'b0, 1'b0, 1'b1, 1'b0);
        bus.pc_next = 32'h0000_0200;
        for (int i = 0; i < 11; i++) begin
            step();
        end
        chk("sat_pre",     {28'd0, bus.stall_cnt}, 32'd14);
        for (int i = 0; i < 9; i++) begin
            step();
        end
        chk("sat_stall",   {28'd0, bus.stall_cnt}, 32'd15);
        chk("sat_pc",      bus.pc,                 32'h0000_0088);
        chk("sat_flush",   {28'd0, bus.flush_cnt}, 32'd2);

        // Reset in the middle of the stall.
        rst_n = 1'b0;
        step();
        chkReset("mrst");

        // Release reset and confirm counting resumes from zero.
        rst_n = 1'b1;
        step();
        chk("post_stall", {28'd0, bus.stall_cnt}, 32'd1);
        chk("post_pc",    bus.pc,                 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
